sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; successor to our fixed 8x16 FIFO.
//  Generic width/depth, true occupancy count, programmable almost-full/almost-empty,
//  same-cycle read+write (incl. at full), overflow/underflow error pulses.
//  Sits between producer/consumer blocks in one clock domain; registered read data.
// PARAMETERS
//  DW       8   data width, bits (>=1)
//  DEPTH    16  entries; power of two, >=2 (non-power-of-two -> elaboration $error)
//  AF_LVL   14  almost_full asserted when count >= AF_LVL (1..DEPTH)
//  AE_LVL   2   almost_empty asserted when count <= AE_LVL (0..DEPTH-1)
//  AW = $clog2(DEPTH), derived, not overridable
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous, active-low reset
//  we            in   1      write request
//  din           in   DW     write data, sampled with we
//  re            in   1      read request
//  dout          out  DW     read data, registered
//  dout_vld      out  1      dout holds the word popped on the previous cycle
//  full          out  1      count == DEPTH
//  empty         out  1      count == 0
//  almost_full   out  1      count >= AF_LVL
//  almost_empty  out  1      count <= AE_LVL
//  count         out  AW+1   current occupancy, 0..DEPTH
//  overflow      out  1      1-cycle pulse: write rejected
//  underflow     out  1      1-cycle pulse: read rejected
// BEHAVIOUR
//  Reset (rst_n low, async): wr_ptr=rd_ptr=0, count=0, dout=0, dout_vld=0, overflow=0,
//   underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=(AF_LVL==0)=0.
//   Memory contents not reset. Reset mid-traffic discards all entries.
//  Pointers AW+1 bits; MSB is wrap bit; address = ptr[AW-1:0]; wrap DEPTH-1 -> 0.
//  Accept rules, evaluated on registered state at posedge:
//   wr_ok = we & (!full | re_ok);   re_ok = re & !empty.
//   Full + we + re: both accepted (read-first RAM), count stays DEPTH.
//   Empty + we + re: write accepted, read rejected (no fall-through), underflow=1.
//   we & full & !re -> overflow=1, no state change for write. re & empty -> underflow=1.
//  count next = count + wr_ok - re_ok; never exceeds DEPTH nor drops below 0.
//  Read latency 1: re_ok in cycle N -> dout = mem[rd_ptr] and dout_vld=1 in cycle N+1;
//   dout holds last value when no read; dout_vld=0 cycles without re_ok.
//  Write: wr_ok -> mem[wr_ptr[AW-1:0]] <= din, wr_ptr++. Rejected writes never touch memory.
//  full/empty/almost_*: combinational decode of registered count only (no in->out paths).
//  overflow/underflow registered, high exactly one cycle per rejected request.
//  Data order strictly FIFO across any number of pointer wraps.
// STRUCTURE
//  fifo_pkg: function clog2-safe helper, localparam defaults (DW/DEPTH), no typedefs needed.
//  Sub-module fifo_dpram #(DW,AW): 1 write port, 1 registered read port, read-before-write
//   on address collision; top holds pointers, count, flags, error pulses.
// TESTING
//  1 Reset: drive rst_n=0 mid-cycle -> all outputs at reset values immediately, count=0.
//  2 Fill: 16 writes 0x01..0x10 -> count 1..16, almost_full at count 14, full after 16th;
//    17th write 0xFF -> overflow pulse 1 cycle, count stays 16, 0xFF never read back.
//  3 Drain: 16 reads -> dout 0x01..0x10 each one cycle after re, dout_vld=1 each;
//    almost_empty at count 2, empty after last; 17th read -> underflow pulse, dout holds 0x10.
//  4 Full + we&re: at count 16 write 0xA5 while reading -> dout=oldest, count stays 16,
//    0xA5 emerges as 16th subsequent read.
//  5 Empty + we&re: din=0x3C -> underflow=1, count=1, next read returns 0x3C.
//  6 Wrap/random: 1000 cycles random we/re vs scoreboard queue, DW=12 DEPTH=8 AF_LVL=7
//    AE_LVL=1 -> zero mismatches, flags match model every cycle; reset asserted at cycle 500
//    -> queue cleared, empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and elaboration-time helpers for the parametrised FIFO.
package fifo_pkg;

    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned DEF_DEPTH = 16;

    // Address width for a given depth; never below 1 so slices stay legal.
    function automatic int unsigned fifo_aw(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, read-before-write.
module fifo_dpram #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int unsigned NWORDS = 1 << AW;

    logic [DW-1:0] mem [NWORDS];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of the old word gives read-before-write on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable thresholds
// and one-cycle overflow/underflow pulses; registered read data.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned AF_LVL = 14,
    parameter int unsigned AE_LVL = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [DW-1:0]              din,
    input  logic                       re,
    output logic [DW-1:0]              dout,
    output logic                       dout_vld,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [fifo_aw(DEPTH):0]    count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned AW = fifo_aw(DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_V    = (AW + 1)'(AF_LVL);
    localparam logic [AW:0] AE_V    = (AW + 1)'(AE_LVL);
    localparam logic [AW:0] ONE     = (AW + 1)'(1);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count_nxt;
    logic        wr_ok;
    logic        re_ok;

    // Flags decode registered count only.
    assign full         = (count == DEPTH_V);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_V);
    assign almost_empty = (count <= AE_V);

    // A read frees a slot in the same cycle, so a full FIFO still takes we&re.
    assign re_ok = re & ~empty;
    assign wr_ok = we & (~full | re_ok);

    always_comb begin
        count_nxt = count;
        case ({wr_ok, re_ok})
            2'b10:   count_nxt = count + ONE;
            2'b01:   count_nxt = count - ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dout_vld  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (re_ok) begin
                rd_ptr <= rd_ptr + ONE;
            end
            count     <= count_nxt;
            dout_vld  <= re_ok;
            overflow  <= we & ~wr_ok;
            underflow <= re & ~re_ok;
        end
    end

    fifo_dpram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (din),
        .rd_en   (re_ok),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (dout)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed checks on a default 8x16 FIFO plus a scoreboarded random run on a 12x8 FIFO.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       rst_n = 1'b0;
    logic       we = 1'b0, re = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       dout_vld, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    sync_fifo_param u_dut (
        .clk (clk), .rst_n (rst_n), .we (we), .din (din), .re (re),
        .dout (dout), .dout_vld (dout_vld), .full (full), .empty (empty),
        .almost_full (almost_full), .almost_empty (almost_empty), .count (count),
        .overflow (overflow), .underflow (underflow)
    );

    // Small instance for wrap/random traffic
    logic        rst_n2 = 1'b0;
    logic        we2 = 1'b0, re2 = 1'b0;
    logic [11:0] din2 = '0;
    logic [11:0] dout2;
    logic        dout_vld2, full2, empty2, almost_full2, almost_empty2, overflow2, underflow2;
    logic [3:0]  count2;

    sync_fifo_param #(.DW(12), .DEPTH(8), .AF_LVL(7), .AE_LVL(1)) u_dut2 (
        .clk (clk), .rst_n (rst_n2), .we (we2), .din (din2), .re (re2),
        .dout (dout2), .dout_vld (dout_vld2), .full (full2), .empty (empty2),
        .almost_full (almost_full2), .almost_empty (almost_empty2), .count (count2),
        .overflow (overflow2), .underflow (underflow2)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] q[$];
    logic [11:0] e_dout;
    logic        e_vld, e_ov, e_uf, rok, wok;
    int          sz;

    initial begin
        // Reset and mid-cycle asynchronous reset
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        we = 1'b1; din = 8'h77; tick();
        we = 1'b0; din = 8'h00; re = 1'b1; tick();
        re = 1'b0; we = 1'b1; din = 8'h55;
        check("pre_rst_dout", 32'(dout), 32'h77);
        tick();
        we = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_dout", 32'(dout), 32'd0);
        check("async_vld", 32'(dout_vld), 32'd0);
        check("async_empty", 32'(empty), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Fill to full, then overflow
        for (int i = 1; i <= 16; i++) begin
            we = 1'b1; din = 8'(i);
            tick();
            check("fill_count", 32'(count), 32'(i));
            check("fill_afull", 32'(almost_full), 32'(i >= 14));
            check("fill_full", 32'(full), 32'(i == 16));
            check("fill_aempty", 32'(almost_empty), 32'(i <= 2));
        end
        din = 8'hFF;
        tick();
        we = 1'b0;
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        tick();
        check("ovf_clear", 32'(overflow), 32'd0);

        // Drain, then underflow
        re = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("drain_dout", 32'(dout), 32'(i));
            check("drain_vld", 32'(dout_vld), 32'd1);
            check("drain_count", 32'(count), 32'(16 - i));
            check("drain_aempty", 32'(almost_empty), 32'((16 - i) <= 2));
            check("drain_empty", 32'(empty), 32'(i == 16));
        end
        tick();
        re = 1'b0;
        check("udf_pulse", 32'(underflow), 32'd1);
        check("udf_dout_hold", 32'(dout), 32'h10);
        check("udf_vld", 32'(dout_vld), 32'd0);
        tick();
        check("udf_clear", 32'(underflow), 32'd0);

        // Full with simultaneous write and read
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; din = 8'(8'h20 + i);
            tick();
        end
        din = 8'hA5; re = 1'b1;
        tick();
        we = 1'b0;
        check("fwr_dout", 32'(dout), 32'h20);
        check("fwr_count", 32'(count), 32'd16);
        check("fwr_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("fwr_drain", 32'(dout), (i == 16) ? 32'hA5 : 32'(8'h20 + i));
        end
        re = 1'b0;
        check("fwr_empty", 32'(empty), 32'd1);

        // Empty with simultaneous write and read
        we = 1'b1; re = 1'b1; din = 8'h3C;
        tick();
        we = 1'b0;
        check("ewr_udf", 32'(underflow), 32'd1);
        check("ewr_count", 32'(count), 32'd1);
        check("ewr_vld", 32'(dout_vld), 32'd0);
        tick();
        re = 1'b0;
        check("ewr_dout", 32'(dout), 32'h3C);
        check("ewr_vld2", 32'(dout_vld), 32'd1);
        check("ewr_count2", 32'(count), 32'd0);

        // Random traffic with pointer wraps against a scoreboard queue
        rst_n2 = 1'b1;
        e_dout = '0;
        tick();
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                we2 = 1'b0; re2 = 1'b0;
                #2 rst_n2 = 1'b0;
                #1;
                q.delete();
                e_dout = '0;
                check("r_rst_empty", 32'(empty2), 32'd1);
                check("r_rst_count", 32'(count2), 32'd0);
                tick();
                rst_n2 = 1'b1;
            end
            we2  = ($urandom_range(0, 99) < ((i % 200) < 100 ? 70 : 35));
            re2  = ($urandom_range(0, 99) < ((i % 200) < 100 ? 35 : 70));
            din2 = 12'($urandom);
            sz   = q.size();
            rok  = re2 && (sz != 0);
            wok  = we2 && ((sz != 8) || rok);
            if (rok) e_dout = q.pop_front();
            if (wok) q.push_back(din2);
            e_vld = rok;
            e_ov  = we2 && !wok;
            e_uf  = re2 && !rok;
            tick();
            sz = q.size();
            check("r_dout", 32'(dout2), 32'(e_dout));
            check("r_vld", 32'(dout_vld2), 32'(e_vld));
            check("r_count", 32'(count2), 32'(sz));
            check("r_ovf", 32'(overflow2), 32'(e_ov));
            check("r_udf", 32'(underflow2), 32'(e_uf));
            check("r_full", 32'(full2), 32'(sz == 8));
            check("r_empty", 32'(empty2), 32'(sz == 0));
            check("r_afull", 32'(almost_full2), 32'(sz >= 7));
            check("r_aempty", 32'(almost_empty2), 32'(sz <= 1));
        end
        we2 = 1'b0; re2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
